soc_clk_nco_gen: RTL and testbench

Parametrised multi-channel clock-enable generator for the soc_system fabric, sitting beside the fixed-ratio PLL and running from its output clock. Each channel has a phase accumulator, a runtime-programmable frequency tuning word and a phase offset. Each channel produces a one-cycle strobe and a square-wave clock of f_refclk·FTW/2^ACC_W. New settings are committed atomically to all channels. A `locked` flag reports settle completion after reset or any reconfiguration.

---
 rtl/soc_clk_nco_pkg.sv | 19 +
 rtl/soc_nco_channel.sv | 59 +++++
 rtl/soc_clk_nco_gen.sv | 109 ++++++++++
 tb/tb_soc_clk_nco_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_clk_nco_pkg.sv
// Shared types and constants for the multi-channel NCO clock-enable generator.
package soc_clk_nco_pkg;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_ACC_W       = 32;
  localparam int unsigned DEF_LOCK_CYCLES = 1024;

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    LOCKED  = 2'd1,
    APPLY   = 2'd2
  } nco_state_t;

  // Settle counter only has to reach cycles-1; keep at least one bit.
  function automatic int unsigned lock_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/soc_nco_channel.sv
// One NCO channel: shadow settings, active tuning word, phase accumulator.
module soc_nco_channel
  import soc_clk_nco_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             commit,
  input  logic             run,
  input  logic [ACC_W-1:0] wr_ftw,
  input  logic [ACC_W-1:0] wr_phase,
  output logic             ce,
  output logic             outclk
);

  logic [ACC_W-1:0] ftw_sh;
  logic [ACC_W-1:0] ph_sh;
  logic [ACC_W-1:0] ftw_act;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // Carry out of the accumulator is the wrap strobe.
  assign sum = {1'b0, acc} + {1'b0, ftw_act};

  // Shadow registers take every accepted write addressed to this channel.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_sh <= '0;
      ph_sh  <= '0;
    end else if (wr_en) begin
      ftw_sh <= wr_ftw;
      ph_sh  <= wr_phase;
    end
  end

  // Commit loads shadows into the running set; otherwise accumulate.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_act <= '0;
      acc     <= '0;
      ce      <= 1'b0;
      outclk  <= 1'b0;
    end else if (commit) begin
      ftw_act <= ftw_sh;
      acc     <= ph_sh;
      ce      <= 1'b0;
      outclk  <= ph_sh[ACC_W-1];
    end else if (run) begin
      acc     <= sum[ACC_W-1:0];
      ce      <= sum[ACC_W];
      outclk  <= sum[ACC_W-1];
    end else begin
      ce      <= 1'b0;
    end
  end

endmodule

// File: rtl/soc_clk_nco_gen.sv
// Multi-channel NCO clock-enable generator with atomic commit and lock flag.
module soc_clk_nco_gen
  import soc_clk_nco_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned ACC_W       = DEF_ACC_W,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int unsigned CNT_W = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  nco_state_t        state;
  nco_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept;
  logic [NUM_CH-1:0] wr_en;
  logic              commit;
  logic              run;

  assign accept = cfg_valid & cfg_ready;
  assign commit = (state == APPLY);
  assign run    = (state != APPLY);

  // Channel decode; out-of-range indices match nothing and are dropped.
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_en[i] = accept && (cfg_ch == CH_W'(i));
    end
  end

  // State, settle counter and the registered handshake/lock outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOCKING;
      cnt       <= '0;
      cfg_ready <= 1'b1;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cfg_ready <= (state_nxt != APPLY);
      locked    <= (state_nxt == LOCKED);
    end
  end

  // Next state: settle count, then hold; an accepted apply always restarts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      LOCKING: begin
        if (cnt == CNT_LAST) begin
          state_nxt = LOCKED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LOCKED: begin
        state_nxt = LOCKED;
      end
      APPLY: begin
        state_nxt = LOCKING;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = LOCKING;
        cnt_nxt   = '0;
      end
    endcase
    if (accept && cfg_apply) begin
      state_nxt = APPLY;
      cnt_nxt   = '0;
    end
  end

  // One accumulator per channel, all committed by the same APPLY cycle.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    soc_nco_channel #(
      .ACC_W (ACC_W)
    ) u_ch (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[g]),
      .commit   (commit),
      .run      (run),
      .wr_ftw   (cfg_ftw),
      .wr_phase (cfg_phase),
      .ce       (ce[g]),
      .outclk   (outclk[g])
    );
  end

endmodule

// File: tb/tb_soc_clk_nco_gen.sv
// Randomised bench for soc_clk_nco_gen against a closed-form phase model.
module tb_soc_clk_nco_gen;

  localparam int unsigned NCH  = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned LC   = 16;
  localparam int unsigned CHW  = 2;

  logic           refclk = 1'b0;
  logic           rst_n  = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  logic [AW-1:0]  cfg_ftw = '0;
  logic [AW-1:0]  cfg_phase = '0;
  logic           cfg_apply = 1'b0;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] outclk;
  logic           locked;

  int total = 0;
  int bad   = 0;

  soc_clk_nco_gen #(
    .NUM_CH      (NCH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LC),
    .CH_W        (CHW)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_ftw   (cfg_ftw),
    .cfg_phase (cfg_phase),
    .cfg_apply (cfg_apply),
    .ce        (ce),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  // Model state: edges since reset release, shadows, and per-channel commit
  // point (phase, ftw, edge) from which acc is a closed-form linear function.
  int              e          = 0;
  int              apply_edge = -10;
  int              lock_edge  = LC;
  logic            m_ready    = 1'b1;
  logic            m_locked   = 1'b0;
  logic [NCH-1:0]  m_ce       = '0;
  logic [NCH-1:0]  m_out      = '0;
  longint unsigned sh_ftw [NCH];
  longint unsigned sh_ph  [NCH];
  longint unsigned a_ftw  [NCH];
  longint unsigned a_ph   [NCH];
  int              c_edge [NCH];
  longint unsigned now_v, prev_v, kk;
  logic            acc_now;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      sh_ftw[i] = 0; sh_ph[i] = 0; a_ftw[i] = 0; a_ph[i] = 0; c_edge[i] = 0;
    end
  end

  // Reference model, updated on each active edge or asynchronous reset.
  initial forever begin
    @(posedge refclk or negedge rst_n);
    if (!rst_n) begin
      e = 0; apply_edge = -10; lock_edge = LC;
      m_ready = 1'b1; m_locked = 1'b0; m_ce = '0; m_out = '0;
      for (int i = 0; i < NCH; i++) begin
        sh_ftw[i] = 0; sh_ph[i] = 0; a_ftw[i] = 0; a_ph[i] = 0; c_edge[i] = 0;
      end
    end else begin
      e = e + 1;
      acc_now = cfg_valid && m_ready;
      if (e == apply_edge + 1) begin
        for (int i = 0; i < NCH; i++) begin
          a_ftw[i] = sh_ftw[i]; a_ph[i] = sh_ph[i]; c_edge[i] = e;
        end
      end
      if (acc_now) begin
        if (int'(cfg_ch) < NCH) begin
          sh_ftw[cfg_ch] = longint'(cfg_ftw);
          sh_ph[cfg_ch]  = longint'(cfg_phase);
        end
        if (cfg_apply) begin
          apply_edge = e;
          lock_edge  = e + 1 + LC;
        end
      end
      m_ready  = (e != apply_edge);
      m_locked = (e >= lock_edge);
      for (int i = 0; i < NCH; i++) begin
        kk    = longint'(e - c_edge[i]);
        now_v = a_ph[i] + a_ftw[i] * kk;
        m_out[i] = now_v[AW-1];
        if (kk == 0) begin
          m_ce[i] = 1'b0;
        end else begin
          prev_v  = a_ph[i] + a_ftw[i] * (kk - 1);
          m_ce[i] = ((now_v >> AW) != (prev_v >> AW));
        end
      end
    end
  end

  // Every-cycle compare of all outputs against the model.
  initial forever begin
    @(negedge refclk);
    check("ce", 64'(ce), 64'(m_ce));
    check("outclk", 64'(outclk), 64'(m_out));
    check("locked", 64'(locked), 64'(m_locked));
    check("cfg_ready", 64'(cfg_ready), 64'(m_ready));
  end

  task automatic wait_edge(input int target);
    while (e < target) @(negedge refclk);
  endtask

  // Called at a negedge; returns the edge number at which the write is accepted.
  task automatic cfg_write(input int ch, input logic [AW-1:0] ftw, input logic [AW-1:0] ph,
                           input logic ap, output int t);
    int g;
    g = 0;
    while (!m_ready && g < 10) begin
      @(negedge refclk);
      g++;
    end
    if (!m_ready) check("ready_timeout", 64'(0), 64'(1));
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_ftw   = ftw;
    cfg_phase = ph;
    cfg_apply = ap;
    t = e + 1;
    @(negedge refclk);
    cfg_valid = 1'b0;
    cfg_apply = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_ftw();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return AW'($urandom());
      2:       return AW'($urandom() >> 3);
      default: return AW'(32'h8000_0000 + $urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int t, t2, cnt;
    // Reset and lock.
    repeat (5) @(negedge refclk);
    check("rst_ce", 64'(ce), 64'(0));
    check("rst_outclk", 64'(outclk), 64'(0));
    check("rst_ready", 64'(cfg_ready), 64'(1));
    check("rst_locked", 64'(locked), 64'(0));
    rst_n = 1'b1;
    wait_edge(LC - 1);
    check("lock_early", 64'(locked), 64'(0));
    wait_edge(LC);
    check("lock_edge", 64'(locked), 64'(1));
    wait_edge(LC + 2);

    // Quarter rate on ch0.
    cfg_write(0, 32'h4000_0000, 32'h0, 1'b1, t);
    for (int k = 0; k < 12; k++) begin
      wait_edge(t + 1 + k);
      check("q_ce0", 64'(ce[0]), 64'(k >= 4 && (k % 4) == 0));
      check("q_out0", 64'(outclk[0]), 64'((k % 4) >= 2));
      check("q_other", 64'(ce[3:1]), 64'(0));
    end

    // Phase offset on ch1.
    cfg_write(1, 32'h8000_0000, 32'h8000_0000, 1'b1, t);
    for (int k = 0; k < 8; k++) begin
      wait_edge(t + 1 + k);
      check("p_ce1", 64'(ce[1]), 64'((k % 2) == 1));
      check("p_out1", 64'(outclk[1]), 64'((k % 2) == 0));
    end

    // Shadow-only write, then an apply-only write elsewhere.
    cfg_write(2, 32'h1000_0000, 32'h0, 1'b0, t);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge refclk);
      cnt += int'(ce[2]) + int'(outclk[2]);
    end
    check("shadow_quiet", 64'(cnt), 64'(0));
    cfg_write(3, 32'h0, 32'h0, 1'b1, t);
    cnt = 0;
    for (int k = 1; k <= 64; k++) begin
      wait_edge(t + 1 + k);
      cnt += int'(ce[2]);
    end
    check("ch2_rate", 64'(cnt), 64'(4));

    // Reapply while still settling.
    cfg_write(0, AW'($urandom()), AW'($urandom()), 1'b1, t);
    check("re1_ready_lo", 64'(cfg_ready), 64'(0));
    wait_edge(t + 1);
    check("re1_ready_hi", 64'(cfg_ready), 64'(1));
    wait_edge(t + 4);
    cfg_write(1, AW'($urandom()), AW'($urandom()), 1'b1, t2);
    check("re_gap", 64'(t2 - t), 64'(5));
    check("re2_ready_lo", 64'(cfg_ready), 64'(0));
    wait_edge(t2 + 1);
    check("re2_ready_hi", 64'(cfg_ready), 64'(1));
    wait_edge(t2 + LC);
    check("re_lock_early", 64'(locked), 64'(0));
    wait_edge(t2 + LC + 1);
    check("re_lock", 64'(locked), 64'(1));

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      cfg_write(int'($urandom_range(0, 3)), rnd_ftw(), AW'($urandom()),
                ($urandom_range(0, 2) == 0), t);
      repeat ($urandom_range(0, 12)) @(negedge refclk);
    end

    // Asynchronous reset with all channels running.
    for (int c = 0; c < 4; c++)
      cfg_write(c, AW'(32'h1000_0000 * (c + 1) + 32'h123), AW'($urandom()), (c == 3), t);
    wait_edge(t + LC + 4);
    check("pre_rst_locked", 64'(locked), 64'(1));
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ce", 64'(ce), 64'(0));
    check("arst_outclk", 64'(outclk), 64'(0));
    check("arst_locked", 64'(locked), 64'(0));
    check("arst_ready", 64'(cfg_ready), 64'(1));
    repeat (3) @(negedge refclk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge refclk);
      cnt += int'(ce != '0);
    end
    check("post_rst_no_ce", 64'(cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
